// File: rtl/auction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : auction_pkg
// Description : Shared types and constants for the sealed-bid auction block.
// Revision    : 1.0 - initial release
// ============================================================================
package auction_pkg;

    localparam int         NBIDDERS  = 10;
    localparam logic [3:0] NO_WINNER = 4'hF;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_AWARD   = 2'd3
    } state_e;

endpackage : auction_pkg
`default_nettype wire

// File: rtl/bid_argmax10.sv
`default_nettype none
// ============================================================================
// Module      : bid_argmax10
// Description : Combinational argmax over 10 bids; only eligible bidders are
//               considered and equal maxima resolve to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
module bid_argmax10
    import auction_pkg::*;
#(
    parameter int bW = 17
) (
    input  logic [NBIDDERS*bW-1:0] bids,
    input  logic [NBIDDERS-1:0]    eligible,
    output logic [3:0]             winner,
    output logic [bW-1:0]          max_val
);

    logic [3:0]    w_best_idx;
    logic [bW-1:0] w_best_val;
    logic          w_found;

    // Linear scan; strict '>' keeps the earliest index on ties
    always_comb begin
        w_best_idx = NO_WINNER;
        w_best_val = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NBIDDERS; i++) begin
            if (eligible[i] && (!w_found || (bids[i*bW +: bW] > w_best_val))) begin
                w_best_idx = 4'(i);
                w_best_val = bids[i*bW +: bW];
                w_found    = 1'b1;
            end
        end
    end

    assign winner  = w_best_idx;
    assign max_val = w_best_val;

endmodule : bid_argmax10
`default_nettype wire

// File: rtl/auction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : auction_ctrl
// Description : Ten-bidder auction controller: opens a bid window on start,
//               accepts one bid per bidder, selects the highest bid and
//               presents the award with valid/ready handshaking.
// Revision    : 1.0 - initial release
// ============================================================================
module auction_ctrl
    import auction_pkg::*;
#(
    parameter int bW     = 17,
    parameter int WINDOW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NBIDDERS-1:0]    bid_valid,
    input  logic [NBIDDERS*bW-1:0] bid_data,
    output logic [NBIDDERS-1:0]    bid_ready,
    output logic                   award_valid,
    input  logic                   award_ready,
    output logic [3:0]             award_winner,
    output logic [bW-1:0]          award_price,
    output logic                   no_bids,
    output logic                   busy
);

    localparam logic [7:0] C_CNT_LOAD = 8'(WINDOW - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [7:0]             r_cnt;
    logic [NBIDDERS-1:0]    r_received;
    logic [NBIDDERS*bW-1:0] r_bids;
    logic                   r_busy;
    logic                   r_award_valid;
    logic [3:0]             r_award_winner;
    logic [bW-1:0]          r_award_price;
    logic                   r_no_bids;

    logic [NBIDDERS-1:0]    w_xfer;
    logic [NBIDDERS-1:0]    w_recv_nxt;
    logic [3:0]             w_winner;
    logic [bW-1:0]          w_max_val;

    // Each bidder is offered exactly one slot per auction
    assign bid_ready  = (r_state == S_COLLECT) ? ~r_received : '0;
    assign w_xfer     = bid_valid & bid_ready;
    assign w_recv_nxt = r_received | w_xfer;

    bid_argmax10 #(
        .bW (bW)
    ) u_argmax (
        .bids     (r_bids),
        .eligible (r_received),
        .winner   (w_winner),
        .max_val  (w_max_val)
    );

    // Next-state decode; window closes on counter expiry or when all have bid
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_COLLECT;
            S_COLLECT: if ((r_cnt == 8'd0) || (&w_recv_nxt)) w_state_nxt = S_EVAL;
            S_EVAL:    w_state_nxt = S_AWARD;
            S_AWARD:   if (award_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State register with busy tracked alongside so it is a clean flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Window counter, received flags and captured bid values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_received <= '0;
            r_bids     <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_cnt      <= C_CNT_LOAD;
                r_received <= '0;
                r_bids     <= '0;
            end
        end else if (r_state == S_COLLECT) begin
            if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            r_received <= w_recv_nxt;
            for (int i = 0; i < NBIDDERS; i++) begin
                if (w_xfer[i]) r_bids[i*bW +: bW] <= bid_data[i*bW +: bW];
            end
        end
    end

    // Award payload is captured in EVAL and held until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_award_valid  <= 1'b0;
            r_award_winner <= 4'h0;
            r_award_price  <= '0;
            r_no_bids      <= 1'b0;
        end else begin
            r_award_valid <= (w_state_nxt == S_AWARD);
            if (r_state == S_EVAL) begin
                r_award_winner <= w_winner;
                r_award_price  <= w_max_val;
                r_no_bids      <= ~(|r_received);
            end
        end
    end

    assign award_valid  = r_award_valid;
    assign award_winner = r_award_winner;
    assign award_price  = r_award_price;
    assign no_bids      = r_no_bids;
    assign busy         = r_busy;

endmodule : auction_ctrl
`default_nettype wire

// File: tb/tb_auction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_auction_ctrl
// Description : Scoreboard bench for auction_ctrl (bW=17, WINDOW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_auction_ctrl;

    localparam int BW = 17;
    localparam int NB = 10;

    logic               clk;
    logic               rst;
    logic               start;
    logic [NB-1:0]      bid_valid;
    logic [NB*BW-1:0]   bid_data;
    logic [NB-1:0]      bid_ready;
    logic               award_valid;
    logic               award_ready;
    logic [3:0]         award_winner;
    logic [BW-1:0]      award_price;
    logic               no_bids;
    logic               busy;

    typedef struct packed {
        logic [3:0]    winner;
        logic [BW-1:0] price;
        logic          nb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   c0       = 0;

    auction_ctrl #(.bW(BW), .WINDOW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bid_valid    (bid_valid),
        .bid_data     (bid_data),
        .bid_ready    (bid_ready),
        .award_valid  (award_valid),
        .award_ready  (award_ready),
        .award_winner (award_winner),
        .award_price  (award_price),
        .no_bids      (no_bids),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare every accepted award against the scoreboard head
    always @(negedge clk) begin
        if (!rst && award_valid && award_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_award", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("award_winner", 32'(award_winner), 32'(e.winner));
                check("award_price",  32'(award_price),  32'(e.price));
                check("no_bids",      32'(no_bids),      32'(e.nb));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_auction();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic set_bid(input int idx, input logic [BW-1:0] val);
        bid_valid[idx] = 1'b1;
        bid_data[idx*BW +: BW] = val;
    endtask

    // Wait (bounded) for award_valid and check its latency from the start edge
    task automatic wait_award(input string name, input int lat);
        int n;
        n = 0;
        while (!award_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_seen"}, 32'(award_valid), 32'd1);
        check({name, "_latency"}, 32'(cyc - c0), 32'(lat));
    endtask

    // Let the pending handshake complete and return to IDLE
    task automatic finish_award();
        tick();
        check("idle_after_award_busy", 32'(busy), 32'd0);
        check("idle_after_award_valid", 32'(award_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bid_valid = '0; bid_data = '0; award_ready = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_award_valid", 32'(award_valid), 32'd0);
        check("rst_bid_ready", 32'(bid_ready), 32'd0);
        check("rst_winner", 32'(award_winner), 32'd0);
        check("rst_price", 32'(award_price), 32'd0);
        check("rst_no_bids", 32'(no_bids), 32'd0);
        rst = 1'b0;
        tick();

        // Three bidders, window expiry
        start_auction();
        check("collect_busy", 32'(busy), 32'd1);
        check("collect_bid_ready", 32'(bid_ready), 32'h3FF);
        set_bid(2, 17'h100); set_bid(5, 17'h3FF); set_bid(7, 17'h200);
        sb.push_back('{winner: 4'd5, price: 17'h3FF, nb: 1'b0});
        tick();
        bid_valid = '0;
        check("bid_ready_after_bids", 32'(bid_ready), 32'h35B);
        wait_award("s1", 5);
        finish_award();

        // All ten bid at once with a tie at the top -> early close
        start_auction();
        for (int i = 0; i < NB; i++) set_bid(i, 17'(i * 16));
        set_bid(3, 17'h1FFFF); set_bid(8, 17'h1FFFF);
        sb.push_back('{winner: 4'd3, price: 17'h1FFFF, nb: 1'b0});
        tick();
        bid_valid = '0;
        wait_award("s2", 2);
        finish_award();

        // Empty window
        start_auction();
        sb.push_back('{winner: 4'hF, price: 17'h0, nb: 1'b1});
        wait_award("s3", 5);
        finish_award();

        // Backpressure and duplicate offers
        award_ready = 1'b0;
        start_auction();
        set_bid(1, 17'h55);
        tick();
        bid_valid = '0;
        set_bid(1, 17'h7777); set_bid(4, 17'h10);
        @(negedge clk);
        check("dup_bid_ready1", 32'(bid_ready[1]), 32'd0);
        tick();
        bid_valid = '0;
        sb.push_back('{winner: 4'd1, price: 17'h55, nb: 1'b0});
        wait_award("s4", 5);
        for (int k = 0; k < 5; k++) begin
            start = 1'b1;
            tick();
            check("bp_valid", 32'(award_valid), 32'd1);
            check("bp_winner", 32'(award_winner), 32'd1);
            check("bp_price", 32'(award_price), 32'h55);
        end
        start = 1'b0;
        award_ready = 1'b1;
        finish_award();

        // Reset in the middle of a collect window
        start_auction();
        set_bid(2, 17'h10); set_bid(6, 17'h20);
        tick();
        bid_valid = '0;
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bid_ready", 32'(bid_ready), 32'd0);
        check("midrst_winner", 32'(award_winner), 32'd0);
        check("midrst_price", 32'(award_price), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("no_award_after_rst", 32'(award_valid), 32'd0);
        check("idle_after_rst", 32'(busy), 32'd0);

        // Fresh auction: a single zero-valued bid still wins
        start_auction();
        set_bid(0, 17'h0);
        sb.push_back('{winner: 4'd0, price: 17'h0, nb: 1'b0});
        tick();
        bid_valid = '0;
        wait_award("s5", 5);
        finish_award();

        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_auction_ctrl
`default_nettype wire
